sseg_scan_driver: RTL and testbench

Time-multiplexed driver for a bank of `DIGITS` common-anode seven-segment digits with per-digit decimal points. It takes a packed hex value plus a DP mask, snapshots both once per refresh frame to prevent tearing, and scans the digits one at a time. Digit switches include an anti-ghosting dead time, and leading zeros can optionally be blanked. It sits between datapath/status registers and the board's segment and anode pins.

---
 rtl/sseg_pkg.sv | 21 ++
 rtl/hex_glyph_rom.sv | 17 +
 rtl/sseg_scan_driver.sv | 122 ++++++++++++
 tb/tb_sseg_scan_driver.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared constants and helpers for the seven-segment scan driver:
// glyph table (active-low, DP bit off), blank pattern and nibble extraction.
package sseg_pkg;

    typedef logic [3:0] nibble_t;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [6:0] SEG_BLANK_AG = 7'h7F;

    // seg[7:1] = a..g, seg[0] = DP; all active-low, DP off here.
    localparam logic [7:0] GLYPH_TABLE [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
    };

    // Pull nibble idx out of a packed value (value zero-extended to 32 bits).
    function automatic nibble_t nibble_at(input logic [31:0] v, input int unsigned idx);
        return nibble_t'(v >> (idx * 4));
    endfunction

endpackage

// File: rtl/hex_glyph_rom.sv
// Combinational hex-to-segment decode; the single place glyphs are looked up.
// A blanked digit keeps its decimal point so DP-only indications still show.
module hex_glyph_rom
    import sseg_pkg::*;
(
    input  nibble_t    nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    logic [7:0] glyph;

    assign glyph = GLYPH_TABLE[nibble];
    assign seg   = {(blank ? SEG_BLANK_AG : glyph[7:1]), ~dp};

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with per-frame snapshot,
// anti-ghosting dead time and optional leading-zero blanking.
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD        = 2
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  blank_lz_en,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(REFRESH_DIV - 1);
    localparam logic [DW-1:0] DIGIT_LAST = DW'(DIGITS - 1);
    localparam logic [TW-1:0] DEAD_TICKS = TW'(DEAD);

    logic [TW-1:0]          tick_reg, tick_next;
    logic [DW-1:0]          digit_reg, digit_next;
    logic [4*DIGITS-1:0]    val_q_reg, val_q_next;
    logic [DIGITS-1:0]      dp_q_reg, dp_q_next;
    logic [7:0]             seg_reg, seg_next;
    logic [DIGITS-1:0]      an_reg, an_next;
    logic                   frame_done_reg, frame_done_next;

    logic                   tick_wrap;
    logic                   frame_wrap;
    logic [DIGITS-1:0]      digit_sel;
    logic [DIGITS-1:0]      blank_mask;
    nibble_t                cur_nibble;
    logic                   cur_dp;
    logic                   cur_blank;
    logic [7:0]             glyph_seg;

    // Next-state counters
    assign tick_wrap  = (tick_reg == TICK_LAST);
    assign frame_wrap = tick_wrap && (digit_reg == DIGIT_LAST);

    always_comb begin
        tick_next  = tick_reg + TW'(1);
        digit_next = digit_reg;
        if (tick_wrap) begin
            tick_next  = '0;
            digit_next = (digit_reg == DIGIT_LAST) ? '0 : digit_reg + DW'(1);
        end
    end

    // Snapshot only at the frame boundary so a frame never mixes two values.
    assign val_q_next = frame_wrap ? value : val_q_reg;
    assign dp_q_next  = frame_wrap ? dp    : dp_q_reg;

    // Digit i is blank when it and every more-significant nibble are zero.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_lz
            if (gi == 0) begin : g_lsd
                assign blank_mask[gi] = 1'b0;
            end else begin : g_upper
                assign blank_mask[gi] = blank_lz_en &&
                                        (val_q_next[4*DIGITS-1:4*gi] == '0);
            end
        end
    endgenerate

    // Outputs are registered from next state so they line up with the state registers.
    assign digit_sel  = DIGITS'(1) << digit_next;
    assign cur_nibble = nibble_at(32'(val_q_next), 32'(digit_next));
    assign cur_dp     = |(dp_q_next & digit_sel);
    assign cur_blank  = |(blank_mask & digit_sel);

    hex_glyph_rom u_glyph (
        .nibble (cur_nibble),
        .dp     (cur_dp),
        .blank  (cur_blank),
        .seg    (glyph_seg)
    );

    always_comb begin
        seg_next = glyph_seg;
        an_next  = ~digit_sel;
        if (tick_next < DEAD_TICKS) begin
            seg_next = SEG_OFF;
            an_next  = '1;
        end
    end

    assign frame_done_next = (tick_next == TICK_LAST) && (digit_next == DIGIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_reg       <= '0;
            digit_reg      <= '0;
            val_q_reg      <= '0;
            dp_q_reg       <= '0;
            seg_reg        <= SEG_OFF;
            an_reg         <= '1;
            frame_done_reg <= 1'b0;
        end else begin
            tick_reg       <= tick_next;
            digit_reg      <= digit_next;
            val_q_reg      <= val_q_next;
            dp_q_reg       <= dp_q_next;
            seg_reg        <= seg_next;
            an_reg         <= an_next;
            frame_done_reg <= frame_done_next;
        end
    end

    assign seg        = seg_reg;
    assign an         = an_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Self-checking bench: frame-position model checked every cycle, plus directed literal checks.
module tb_sseg_scan_driver;

    localparam int D  = 4;
    localparam int R  = 4;
    localparam int DT = 1;
    localparam int F  = D * R;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        blank_lz_en;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    always #5 clk = ~clk;

    sseg_scan_driver #(.DIGITS(D), .REFRESH_DIV(R), .DEAD(DT)) dut (
        .clk         (clk),
        .rst         (rst),
        .value       (value),
        .dp          (dp),
        .blank_lz_en (blank_lz_en),
        .seg         (seg),
        .an          (an),
        .frame_done  (frame_done)
    );

    int checks = 0;
    int fails  = 0;

    localparam logic [7:0] GL [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
    };

    // Model: position within the frame, snapshot taken when position returns to 0.
    int          mpos = 0;
    logic [15:0] msnap = '0;
    logic [3:0]  mdp = '0;
    logic        mblz = 1'b0;
    bit          started = 0;

    always @(posedge clk) begin
        started = 1;
        mblz = blank_lz_en;
        if (rst) begin
            mpos  = 0;
            msnap = '0;
            mdp   = '0;
        end else begin
            mpos = (mpos + 1) % F;
            if (mpos == 0) begin
                msnap = value;
                mdp   = dp;
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    int          e_d, e_t;
    logic [7:0]  e_seg, e_g;
    logic [3:0]  e_an, e_nib;
    logic        e_fd, e_blank;

    always @(negedge clk) begin
        if (started) begin
            e_d  = mpos / R;
            e_t  = mpos % R;
            e_fd = (mpos == F - 1);
            if (e_t < DT) begin
                e_seg = 8'hFF;
                e_an  = 4'hF;
            end else begin
                e_an    = ~(4'b0001 << e_d);
                e_nib   = msnap[4*e_d +: 4];
                e_g     = GL[e_nib];
                e_blank = mblz && (e_d > 0) && ((msnap >> (4 * e_d)) == 16'h0);
                e_seg   = {(e_blank ? 7'h7F : e_g[7:1]), ~mdp[e_d]};
            end
            chk("model_seg", seg, e_seg);
            chk("model_an", {4'h0, an}, {4'h0, e_an});
            chk("model_frame_done", {7'h0, frame_done}, {7'h0, e_fd});
        end
    end

    task automatic goto(input int d, input int t);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (mpos != d * R + t && k < 200);
        if (mpos != d * R + t) begin
            checks++;
            fails++;
            $display("FAIL goto_timeout: pos %0d required %0d", mpos, d * R + t);
        end
    endtask

    // Counts cycles from a reset release until frame_done shows.
    task automatic count_to_frame_done(input string name);
        int cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (cnt == 2) begin
                chk({name, "_digit0_seg"}, seg, 8'h03);
                chk({name, "_digit0_an"}, {4'h0, an}, 8'h0E);
            end
        end while (!frame_done && cnt < 100);
        chk({name, "_frame_done_cycle"}, 8'(cnt), 8'd15);
    endtask

    initial begin
        rst = 1'b1;
        value = 16'h1234;
        dp = 4'b0000;
        blank_lz_en = 1'b0;

        // Reset held for three cycles
        repeat (3) @(negedge clk);
        chk("reset_seg", seg, 8'hFF);
        chk("reset_an", {4'h0, an}, 8'h0F);
        chk("reset_fd", {7'h0, frame_done}, 8'h00);
        rst = 1'b0;
        count_to_frame_done("first_frame");

        // Scan of 1234 in the second frame
        goto(0, 0);
        chk("scan_dead_seg", seg, 8'hFF);
        chk("scan_dead_an", {4'h0, an}, 8'h0F);
        goto(0, 1); chk("scan_d0_seg", seg, 8'h99); chk("scan_d0_an", {4'h0, an}, 8'h0E);
        goto(1, 1); chk("scan_d1_seg", seg, 8'h0D); chk("scan_d1_an", {4'h0, an}, 8'h0D);
        goto(2, 1); chk("scan_d2_seg", seg, 8'h25);
        goto(3, 1); chk("scan_d3_seg", seg, 8'h9F); chk("scan_d3_an", {4'h0, an}, 8'h07);

        // Tearing: mid-frame change must wait for the next frame
        value = 16'hABCD;
        goto(0, 1); chk("tear_d0", seg, 8'h85);
        value = 16'h5678;
        goto(1, 1); chk("tear_d1", seg, 8'h63);
        goto(2, 1); chk("tear_d2", seg, 8'hC1);
        goto(3, 1); chk("tear_d3", seg, 8'h11);
        goto(0, 1); chk("next_d0", seg, 8'h01);
        goto(1, 1); chk("next_d1", seg, 8'h1F);
        goto(2, 1); chk("next_d2", seg, 8'h41);
        goto(3, 1); chk("next_d3", seg, 8'h49);

        // DP mask and glyph sweep
        dp = 4'b0101;
        value = 16'h0123;
        goto(0, 1); chk("dp_d0", seg, 8'h0C);
        goto(1, 1); chk("dp_d1", seg, 8'h25);
        goto(2, 1); chk("dp_d2", seg, 8'h9E);
        goto(3, 1); chk("dp_d3", seg, 8'h03);
        value = 16'h4567; goto(3, 3);
        value = 16'h89AB; goto(3, 3);
        value = 16'hCDEF; goto(3, 3);
        goto(0, 1); chk("dp_sweep_F", seg, 8'h70);
        goto(3, 1); chk("dp_sweep_C", seg, 8'h63);
        goto(3, 3);

        // Leading-zero blanking
        blank_lz_en = 1'b1;
        value = 16'h0040;
        dp = 4'b1000;
        goto(0, 1); chk("lz_d0", seg, 8'h03);
        goto(1, 1); chk("lz_d1", seg, 8'h99);
        goto(2, 1); chk("lz_d2", seg, 8'hFF);
        goto(3, 1); chk("lz_d3", seg, 8'hFE);
        value = 16'h0000;
        dp = 4'b0000;
        goto(0, 1); chk("lz0_d0", seg, 8'h03);
        goto(1, 1); chk("lz0_d1", seg, 8'hFF);
        goto(2, 1); chk("lz0_d2", seg, 8'hFF);
        goto(3, 1); chk("lz0_d3", seg, 8'hFF);
        blank_lz_en = 1'b0;

        // Mid-frame reset at state (2,2)
        value = 16'h9876;
        goto(2, 2);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_seg", seg, 8'hFF);
        chk("midrst_an", {4'h0, an}, 8'h0F);
        chk("midrst_fd", {7'h0, frame_done}, 8'h00);
        rst = 1'b0;
        count_to_frame_done("after_midrst");
        goto(0, 1); chk("after_midrst_live", seg, 8'h41);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
